// File: rtl/fir_structs.sv
// rtl/fir_structs.sv - shared FIR types and default sizing constants
package fir_structs;

    localparam int FIR_DATA_W   = 32;
    localparam int FIR_DEPTH    = 8;
    localparam int FIR_NUM_COEF = 8;

    typedef enum logic [1:0] {
        CTRL_IDLE,
        CTRL_MAC,
        CTRL_EMIT
    } ctrl_state_t;

    typedef enum logic {
        LOAD,
        LOADED
    } coef_state_t;

endpackage

// File: rtl/fir_fifo_ram.sv
// rtl/fir_fifo_ram.sv - DEPTH x DATA_W sample storage, sync write, registered read
module fir_fifo_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read register holds the last popped sample until the next accepted read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fir_input_stager.sv
// rtl/fir_input_stager.sv - sample FIFO write side and coefficient load sequencer
module fir_input_stager
    import fir_structs::*;
#(
    parameter int DATA_W   = FIR_DATA_W,
    parameter int DEPTH    = FIR_DEPTH,
    parameter int NUM_COEF = FIR_NUM_COEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        PushIn,
    input  logic [DATA_W-1:0]           DataIn,
    input  logic                        PushCoef,
    input  logic [DATA_W-1:0]           CoefIn,
    input  logic                        fifoPullOut,
    output logic                        fifo_empty,
    output logic                        fifo_full,
    output logic [DATA_W-1:0]           fifo_data,
    output logic                        CoefWrite,
    output logic [$clog2(NUM_COEF)-1:0] CoefAddr,
    output logic [DATA_W-1:0]           CoefData,
    output logic                        coef_loaded,
    output logic                        overflow,
    output logic                        underflow
);

    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int CAW = $clog2(NUM_COEF);
    localparam logic [CAW-1:0] LAST_COEF = CAW'(NUM_COEF - 1);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push_ok;
    logic          pull_ok;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CW'(DEPTH));
    assign push_ok    = PushIn && !fifo_full;
    assign pull_ok    = fifoPullOut && !fifo_empty;

    fir_fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (PW)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push_ok),
        .wr_addr (wr_ptr),
        .wr_data (DataIn),
        .rd_en   (pull_ok),
        .rd_addr (rd_ptr),
        .rd_data (fifo_data)
    );

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pull_ok) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_ok, pull_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (PushIn && fifo_full) begin
                overflow <= 1'b1;
            end
            if (fifoPullOut && fifo_empty) begin
                underflow <= 1'b1;
            end
        end
    end

    coef_state_t    coef_state;
    coef_state_t    coef_state_nxt;
    logic [CAW-1:0] coef_cnt;
    logic [CAW-1:0] coef_cnt_nxt;

    always_comb begin
        coef_state_nxt = coef_state;
        coef_cnt_nxt   = coef_cnt;
        if (PushCoef) begin
            coef_cnt_nxt = (coef_cnt == LAST_COEF) ? '0 : coef_cnt + CAW'(1);
        end
        case (coef_state)
            LOAD: begin
                if (PushCoef && (coef_cnt == LAST_COEF)) begin
                    coef_state_nxt = LOADED;
                end
            end
            LOADED:  coef_state_nxt = LOADED;
            default: coef_state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            coef_state <= LOAD;
            coef_cnt   <= '0;
            CoefWrite  <= 1'b0;
            CoefAddr   <= '0;
            CoefData   <= '0;
        end else begin
            coef_state <= coef_state_nxt;
            coef_cnt   <= coef_cnt_nxt;
            CoefWrite  <= PushCoef;
            if (PushCoef) begin
                CoefAddr <= coef_cnt;
                CoefData <= CoefIn;
            end
        end
    end

    assign coef_loaded = (coef_state == LOADED);

endmodule

// File: tb/tb_fir_input_stager.sv
// tb/tb_fir_input_stager.sv - scoreboard bench for fir_input_stager
module tb_fir_input_stager;

    localparam int DATA_W   = 32;
    localparam int DEPTH    = 8;
    localparam int NUM_COEF = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              PushIn = 1'b0;
    logic [DATA_W-1:0] DataIn = '0;
    logic              PushCoef = 1'b0;
    logic [DATA_W-1:0] CoefIn = '0;
    logic              fifoPullOut = 1'b0;
    logic              fifo_empty;
    logic              fifo_full;
    logic [DATA_W-1:0] fifo_data;
    logic              CoefWrite;
    logic [2:0]        CoefAddr;
    logic [DATA_W-1:0] CoefData;
    logic              coef_loaded;
    logic              overflow;
    logic              underflow;

    always #5 clk = ~clk;

    fir_input_stager #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .NUM_COEF (NUM_COEF)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .PushIn      (PushIn),
        .DataIn      (DataIn),
        .PushCoef    (PushCoef),
        .CoefIn      (CoefIn),
        .fifoPullOut (fifoPullOut),
        .fifo_empty  (fifo_empty),
        .fifo_full   (fifo_full),
        .fifo_data   (fifo_data),
        .CoefWrite   (CoefWrite),
        .CoefAddr    (CoefAddr),
        .CoefData    (CoefData),
        .coef_loaded (coef_loaded),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] mq[$];
    logic [31:0] exp_data[$];
    logic [63:0] exp_coef[$];
    logic [31:0] m_data;
    bit          m_ovf;
    bit          m_unf;
    bit          m_loaded;
    int          m_caddr;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic do_reset();
        reset       = 1'b0;
        PushIn      = 1'b0;
        fifoPullOut = 1'b0;
        PushCoef    = 1'b0;
        #1;
        mq.delete();
        exp_data.delete();
        exp_coef.delete();
        m_data   = '0;
        m_ovf    = 1'b0;
        m_unf    = 1'b0;
        m_loaded = 1'b0;
        m_caddr  = 0;
        chk("rst_empty", fifo_empty, 1);
        chk("rst_full", fifo_full, 0);
        chk("rst_data", fifo_data, 0);
        chk("rst_cwrite", CoefWrite, 0);
        chk("rst_caddr", CoefAddr, 0);
        chk("rst_cdata", CoefData, 0);
        chk("rst_loaded", coef_loaded, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_unf", underflow, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic cycle(input logic push, input logic [31:0] din, input logic pull,
                         input logic pc, input logic [31:0] cin);
        bit full, empty, pull_ok;
        logic [63:0] ec;
        PushIn      = push;
        DataIn      = din;
        fifoPullOut = pull;
        PushCoef    = pc;
        CoefIn      = cin;
        full    = (mq.size() == DEPTH);
        empty   = (mq.size() == 0);
        pull_ok = pull && !empty;
        if (push && full) m_ovf = 1'b1;
        if (pull && empty) m_unf = 1'b1;
        if (pull_ok) exp_data.push_back(mq.pop_front());
        if (push && !full) mq.push_back(din);
        if (pc) begin
            exp_coef.push_back({32'(m_caddr), cin});
            if (m_caddr == NUM_COEF - 1) begin
                m_caddr  = 0;
                m_loaded = 1'b1;
            end else begin
                m_caddr++;
            end
        end
        @(posedge clk);
        #1;
        PushIn      = 1'b0;
        fifoPullOut = 1'b0;
        PushCoef    = 1'b0;
        if (pull_ok) m_data = exp_data.pop_front();
        chk("fifo_data", fifo_data, m_data);
        chk("fifo_empty", fifo_empty, mq.size() == 0);
        chk("fifo_full", fifo_full, mq.size() == DEPTH);
        chk("overflow", overflow, m_ovf);
        chk("underflow", underflow, m_unf);
        chk("coef_loaded", coef_loaded, m_loaded);
        chk("coef_write", CoefWrite, pc);
        if (pc) begin
            ec = exp_coef.pop_front();
            chk("coef_addr", CoefAddr, ec[63:32]);
            chk("coef_data", CoefData, ec[31:0]);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 1 && mq.size() > 0; i++) cycle(0, 0, 1, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        cycle(1, 32'h11, 0, 0, 0);
        cycle(1, 32'h22, 0, 0, 0);
        cycle(1, 32'h33, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, 0);

        for (int i = 1; i <= DEPTH + 1; i++) cycle(1, 32'(i), 0, 0, 0);
        drain();

        for (int i = 1; i <= DEPTH; i++) cycle(1, 32'(i), 0, 0, 0);
        cycle(1, 32'hAA, 1, 0, 0);
        drain();

        for (int i = 0; i < 5; i++) cycle(1, 32'h100 + 32'(i), 0, 0, 0);
        do_reset();
        cycle(1, 32'h77, 0, 0, 0);
        cycle(0, 0, 1, 0, 0);

        do_reset();
        cycle(1, 32'h55, 1, 0, 0);
        cycle(0, 0, 1, 0, 0);

        for (int i = 0; i <= NUM_COEF; i++) cycle(0, 0, 0, 1, 32'hC000_0000 + 32'(i));

        for (int i = 0; i < 40; i++)
            cycle(($urandom_range(0, 3) != 0), $urandom, ($urandom_range(0, 3) != 0),
                  $urandom_range(0, 1), $urandom);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fir_input_stager.md
# fir_input_stager

Write side of the FIR sample FIFO. Accepts sample pushes and coefficient pushes from the chip boundary. Buffers samples in a circular FIFO that the multiplier/accumulator controller drains with `fifoPullOut`/`fifo_empty`. Sequences coefficients into the coefficient register file with an auto-incrementing address.

## Interface
Parameters:
- DATA_W, 32, sample and coefficient width
- DEPTH, 8, FIFO entries; power of two, at least 2
- NUM_COEF, 8, coefficient count; address wraps after NUM_COEF-1

Ports:
- clk  in  1  single clock, all state rising-edge
- reset  in  1  asynchronous, active-low
- PushIn  in  1  sample valid this cycle
- DataIn  in  DATA_W  sample value
- PushCoef  in  1  coefficient valid this cycle
- CoefIn  in  DATA_W  coefficient value
- fifoPullOut  in  1  pop request from the controller
- fifo_empty  out  1  no stored samples
- fifo_full  out  1  DEPTH samples stored
- fifo_data  out  DATA_W  last popped sample, registered
- CoefWrite  out  1  coefficient write strobe
- CoefAddr  out  $clog2(NUM_COEF)  coefficient write address
- CoefData  out  DATA_W  coefficient write data
- coef_loaded  out  1  full coefficient set written since reset
- overflow  out  1  sticky: push dropped while full
- underflow  out  1  sticky: pull ignored while empty

## Operation
- State: write pointer, read pointer, occupancy count (0..DEPTH), coefficient address counter, sticky flags.
- `fifo_empty` = (count==0). `fifo_full` = (count==DEPTH). Both are decoded from registered count and are not combinational from inputs.
- Push accepted iff PushIn && !fifo_full, using pre-edge state. The entry is written at the write pointer, then the write pointer increments modulo DEPTH.
- Pull accepted iff fifoPullOut && !fifo_empty, using pre-edge state. fifo_data loads the head entry, then the read pointer increments modulo DEPTH.
- Simultaneous accepted push and pull: count unchanged and both pointers advance.
- Push while full: dropped even if a pull occurs in the same cycle; overflow <= 1.
- Pull while empty: ignored even if a push occurs in the same cycle; fifo_data holds; underflow <= 1.
- fifo_data holds its value in every cycle without an accepted pull.
- Coefficient FSM has states LOAD and LOADED.
  - Each PushCoef registers CoefWrite=1, CoefAddr=counter, CoefData=CoefIn, then increments the counter.
  - At counter==NUM_COEF-1 the counter wraps to 0 and the FSM moves LOAD->LOADED. coef_loaded=1 in LOADED.
  - In LOADED, further PushCoef continues overwriting from address 0. The FSM stays in LOADED.
- The coefficient path is independent of the sample path; PushIn and PushCoef may be asserted in the same cycle.
- Sticky flags clear only on reset.

## Timing
- Reset values (asynchronous, while reset==0):
  - pointers, count and coefficient counter 0; FSM LOAD
  - fifo_empty=1, fifo_full=0, fifo_data=0
  - CoefWrite=0, CoefAddr=0, CoefData=0
  - coef_loaded=0, overflow=0, underflow=0
- Reset asserted mid-operation discards all stored samples immediately; no pending write completes.
- Push to empty FIFO: fifo_empty deasserts the cycle after the PushIn edge.
- Pull latency: fifo_data is valid the cycle after the edge where the pull is accepted. The controller samples it no earlier than that cycle.
- Coefficient latency: CoefWrite pulses for exactly one cycle, one cycle after each PushCoef. Back-to-back PushCoef gives consecutive strobes with consecutive addresses.
- Sustained throughput is one push and one pull per cycle.

## Structure
- Shared package fir_structs holds:
  - the coefficient state enum (LOAD, LOADED) alongside the existing controller enums
  - default DATA_W, DEPTH, NUM_COEF constants
- Sub-module fir_fifo_ram is the DEPTH x DATA_W storage array. It has a single synchronous write port and a registered read port. Pointer, count and flag logic stay in fir_input_stager.

## Test plan
- Reset then push 0x11, 0x22, 0x33, then three pulls: fifo_data reads 0x11, 0x22, 0x33 on the cycles after each pull; fifo_empty=1 after the third pull; no sticky flags set.
- Push DEPTH+1 values 1..9 (DEPTH=8): fifo_full after the 8th push; the 9th push is dropped; overflow=1; draining returns 1..8 only.
- Fill to 8 then push 0xAA with a simultaneous pull: pull returns 1, 0xAA is dropped, overflow=1, count=7.
- Empty FIFO with PushIn=0x55 and fifoPullOut in the same cycle: underflow=1, fifo_data stays 0, count=1; the next pull returns 0x55.
- Push coefficients C0..C7 back-to-back: CoefWrite strobes at addresses 0..7 with matching data; coef_loaded rises after the 8th; a 9th push writes address 0.
- Reset asserted with 5 samples stored: fifo_empty=1 and all outputs return to reset values immediately; after release, push 0x77 then pull returns 0x77.
